// File: rtl/register_file.sv
// register_file: REG_COUNT x DATA_WIDTH storage with two combinational read
// ports, one clocked write port, optional hardwired-zero R0, optional
// write-to-read bypass and a dedicated up/down pointer register.
module register_file #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           REG_COUNT  = 8,
  parameter int unsigned           ADDR_WIDTH = 3,
  parameter bit                    ZERO_R0    = 1'b0,
  parameter bit                    BYPASS     = 1'b1,
  parameter int unsigned           SP_ADDR    = REG_COUNT - 1,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [ADDR_WIDTH-1:0] RADDR_A,
  input  logic [ADDR_WIDTH-1:0] RADDR_B,
  output logic [DATA_WIDTH-1:0] RDATA_A,
  output logic [DATA_WIDTH-1:0] RDATA_B,
  input  logic                  SP_INC,
  input  logic                  SP_DEC,
  output logic [DATA_WIDTH-1:0] SP_OUT
);

  // Elaboration-time sanity checks on the parameter set.
  if (REG_COUNT < 2) begin : g_chk_count
    $error("register_file: REG_COUNT must be at least 2");
  end
  if ((64'(1) << ADDR_WIDTH) < 64'(REG_COUNT)) begin : g_chk_addr
    $error("register_file: ADDR_WIDTH too small for REG_COUNT");
  end
  if (SP_ADDR >= REG_COUNT) begin : g_chk_sp_range
    $error("register_file: SP_ADDR must be below REG_COUNT");
  end
  if (ZERO_R0 && (SP_ADDR == 0)) begin : g_chk_sp_zero
    $error("register_file: SP_ADDR cannot be 0 when R0 is hardwired");
  end

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic                  wr_en;
  logic                  wr_sp;
  logic [DATA_WIDTH-1:0] sp_cur;
  logic                  sp_step;
  logic [DATA_WIDTH-1:0] sp_next;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  // Qualify the write: in range and not aimed at a hardwired R0.
  always_comb begin
    wr_en = 1'b0;
    wr_sp = 1'b0;
    if (WE && (32'(WADDR) < REG_COUNT)) begin
      wr_en = 1'b1;
    end
    if (ZERO_R0 && (WADDR == '0)) begin
      wr_en = 1'b0;
    end
    if (wr_en && (32'(WADDR) == SP_ADDR)) begin
      wr_sp = 1'b1;
    end
  end

  // Pointer step: opposing requests cancel; arithmetic wraps naturally.
  always_comb begin
    sp_cur = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (i == SP_ADDR) begin
        sp_cur = regs[i];
      end
    end
    sp_step = (SP_INC ^ SP_DEC) && !wr_sp;
    sp_next = SP_INC ? (sp_cur + DATA_WIDTH'(1)) : (sp_cur - DATA_WIDTH'(1));
  end

  // Storage update: reset beats a write, a write beats a pointer step.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= (i == SP_ADDR) ? SP_RESET : '0;
      end
    end else begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (wr_en && (WADDR == ADDR_WIDTH'(i))) begin
          regs[i] <= WDATA;
        end else if ((i == SP_ADDR) && sp_step) begin
          regs[i] <= sp_next;
        end
      end
    end
  end

  // Read muxes: out-of-range reads give 0, R0 may be forced to 0, and an
  // accepted write to the same address can be forwarded straight through.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (RADDR_A == ADDR_WIDTH'(i)) begin
        rd_a = regs[i];
      end
      if (RADDR_B == ADDR_WIDTH'(i)) begin
        rd_b = regs[i];
      end
    end
    if (ZERO_R0 && (RADDR_A == '0)) begin
      rd_a = '0;
    end
    if (ZERO_R0 && (RADDR_B == '0)) begin
      rd_b = '0;
    end
    if (BYPASS && wr_en && (RADDR_A == WADDR)) begin
      rd_a = WDATA;
    end
    if (BYPASS && wr_en && (RADDR_B == WADDR)) begin
      rd_b = WDATA;
    end
  end

  assign RDATA_A = rd_a;
  assign RDATA_B = rd_b;
  assign SP_OUT  = sp_cur;

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file in two configurations:
// dut_a (bypass on, normal R0) and dut_b (bypass off, hardwired R0).
module tb_register_file;

  logic       CLK;
  logic       RST;
  logic       WE;
  logic [3:0] WADDR;
  logic [7:0] WDATA;
  logic [3:0] RADDR_A;
  logic [3:0] RADDR_B;
  logic       SP_INC;
  logic       SP_DEC;

  logic [7:0] a_rd_a, a_rd_b, a_sp;
  logic [7:0] b_rd_a, b_rd_b, b_sp;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [2][8];

  register_file #(
    .DATA_WIDTH(8), .REG_COUNT(8), .ADDR_WIDTH(4),
    .ZERO_R0(1'b0), .BYPASS(1'b1), .SP_ADDR(7), .SP_RESET(8'hF0)
  ) dut_a (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RADDR_A(RADDR_A), .RADDR_B(RADDR_B), .RDATA_A(a_rd_a), .RDATA_B(a_rd_b),
    .SP_INC(SP_INC), .SP_DEC(SP_DEC), .SP_OUT(a_sp)
  );

  register_file #(
    .DATA_WIDTH(8), .REG_COUNT(8), .ADDR_WIDTH(4),
    .ZERO_R0(1'b1), .BYPASS(1'b0), .SP_ADDR(7), .SP_RESET(8'hF0)
  ) dut_b (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RADDR_A(RADDR_A), .RADDR_B(RADDR_B), .RDATA_A(b_rd_a), .RDATA_B(b_rd_b),
    .SP_INC(SP_INC), .SP_DEC(SP_DEC), .SP_OUT(b_sp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] ea, eb;
    RST = 1'b1; WE = 1'b1; WADDR = 4'd2; WDATA = 8'h11;
    SP_INC = 1'b0; SP_DEC = 1'b0; RADDR_A = '0; RADDR_B = '0;
    tick;
    RST = 1'b0; WE = 1'b0;
    for (int i = 0; i < 16; i++) begin
      RADDR_A = 4'(i);
      RADDR_B = 4'(15 - i);
      #1;
      ea = (i == 7) ? 8'hF0 : 8'h00;
      eb = ((15 - i) == 7) ? 8'hF0 : 8'h00;
      total += 4;
      if (a_rd_a !== ea) begin bad++; $display("FAIL reset_a_rda[%0d]: got %h want %h", i, a_rd_a, ea); end
      if (a_rd_b !== eb) begin bad++; $display("FAIL reset_a_rdb[%0d]: got %h want %h", 15 - i, a_rd_b, eb); end
      if (b_rd_a !== ea) begin bad++; $display("FAIL reset_b_rda[%0d]: got %h want %h", i, b_rd_a, ea); end
      if (b_rd_b !== eb) begin bad++; $display("FAIL reset_b_rdb[%0d]: got %h want %h", 15 - i, b_rd_b, eb); end
    end
    total += 2;
    if (a_sp !== 8'hF0) begin bad++; $display("FAIL reset_a_sp: got %h want f0", a_sp); end
    if (b_sp !== 8'hF0) begin bad++; $display("FAIL reset_b_sp: got %h want f0", b_sp); end
  endtask

  task automatic test_write_bypass;
    tick;
    WE = 1'b1; WADDR = 4'd3; WDATA = 8'hA5; RADDR_A = 4'd3; RADDR_B = 4'd3;
    #1;
    total += 4;
    if (a_rd_a !== 8'hA5) begin bad++; $display("FAIL byp_a_rda: got %h want a5", a_rd_a); end
    if (a_rd_b !== 8'hA5) begin bad++; $display("FAIL byp_a_rdb: got %h want a5", a_rd_b); end
    if (b_rd_a !== 8'h00) begin bad++; $display("FAIL nobyp_b_rda: got %h want 00", b_rd_a); end
    if (b_rd_b !== 8'h00) begin bad++; $display("FAIL nobyp_b_rdb: got %h want 00", b_rd_b); end
    tick;
    WE = 1'b0;
    #1;
    total += 3;
    if (b_rd_a !== 8'hA5) begin bad++; $display("FAIL wr_b_rda: got %h want a5", b_rd_a); end
    if (b_rd_b !== 8'hA5) begin bad++; $display("FAIL wr_b_rdb: got %h want a5", b_rd_b); end
    if (a_rd_a !== 8'hA5) begin bad++; $display("FAIL wr_a_rda: got %h want a5", a_rd_a); end
  endtask

  task automatic test_invalid_write;
    logic [7:0] e;
    tick;
    WE = 1'b1; WADDR = 4'd9; WDATA = 8'h3C; RADDR_A = 4'd9; RADDR_B = 4'd3;
    #1;
    total += 2;
    if (a_rd_a !== 8'h00) begin bad++; $display("FAIL inv_a_rda: got %h want 00", a_rd_a); end
    if (a_rd_b !== 8'hA5) begin bad++; $display("FAIL inv_a_rdb: got %h want a5", a_rd_b); end
    tick;
    WE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RADDR_A = 4'(i);
      #1;
      e = (i == 3) ? 8'hA5 : ((i == 7) ? 8'hF0 : 8'h00);
      total += 2;
      if (a_rd_a !== e) begin bad++; $display("FAIL inv_sweep_a[%0d]: got %h want %h", i, a_rd_a, e); end
      if (b_rd_a !== e) begin bad++; $display("FAIL inv_sweep_b[%0d]: got %h want %h", i, b_rd_a, e); end
    end
  endtask

  task automatic test_zero_r0;
    tick;
    WE = 1'b1; WADDR = 4'd0; WDATA = 8'h55; RADDR_A = 4'd0; RADDR_B = 4'd0;
    #1;
    total += 2;
    if (a_rd_a !== 8'h55) begin bad++; $display("FAIL r0_byp_a: got %h want 55", a_rd_a); end
    if (b_rd_a !== 8'h00) begin bad++; $display("FAIL r0_byp_b: got %h want 00", b_rd_a); end
    tick;
    WE = 1'b0;
    #1;
    total += 2;
    if (a_rd_a !== 8'h55) begin bad++; $display("FAIL r0_a: got %h want 55", a_rd_a); end
    if (b_rd_b !== 8'h00) begin bad++; $display("FAIL r0_b: got %h want 00", b_rd_b); end
  endtask

  task automatic test_pointer;
    tick;
    WE = 1'b1; WADDR = 4'd7; WDATA = 8'hFF;
    tick;
    WE = 1'b0; RADDR_A = 4'd7;
    #1;
    total += 2;
    if (a_sp !== 8'hFF) begin bad++; $display("FAIL sp_load_a: got %h want ff", a_sp); end
    if (b_sp !== 8'hFF) begin bad++; $display("FAIL sp_load_b: got %h want ff", b_sp); end
    SP_INC = 1'b1;
    #1;
    total += 2;
    if (a_rd_a !== 8'hFF) begin bad++; $display("FAIL sp_prestep_a: got %h want ff", a_rd_a); end
    if (b_rd_a !== 8'hFF) begin bad++; $display("FAIL sp_prestep_b: got %h want ff", b_rd_a); end
    tick;
    SP_INC = 1'b0;
    #1;
    total += 3;
    if (a_sp !== 8'h00) begin bad++; $display("FAIL sp_inc_wrap_a: got %h want 00", a_sp); end
    if (b_sp !== 8'h00) begin bad++; $display("FAIL sp_inc_wrap_b: got %h want 00", b_sp); end
    if (a_rd_a !== 8'h00) begin bad++; $display("FAIL sp_inc_rd_a: got %h want 00", a_rd_a); end
    SP_DEC = 1'b1;
    tick;
    SP_DEC = 1'b0;
    #1;
    total += 2;
    if (a_sp !== 8'hFF) begin bad++; $display("FAIL sp_dec_wrap_a: got %h want ff", a_sp); end
    if (b_sp !== 8'hFF) begin bad++; $display("FAIL sp_dec_wrap_b: got %h want ff", b_sp); end
    SP_INC = 1'b1; SP_DEC = 1'b1;
    tick;
    SP_INC = 1'b0; SP_DEC = 1'b0;
    #1;
    total += 2;
    if (a_sp !== 8'hFF) begin bad++; $display("FAIL sp_both_a: got %h want ff", a_sp); end
    if (b_sp !== 8'hFF) begin bad++; $display("FAIL sp_both_b: got %h want ff", b_sp); end
  endtask

  task automatic test_conflict;
    WE = 1'b1; WADDR = 4'd7; WDATA = 8'h10;
    tick;
    WDATA = 8'h40; SP_INC = 1'b1;
    tick;
    WE = 1'b0; SP_INC = 1'b0;
    #1;
    total += 2;
    if (a_sp !== 8'h40) begin bad++; $display("FAIL conf_wr_sp_a: got %h want 40", a_sp); end
    if (b_sp !== 8'h40) begin bad++; $display("FAIL conf_wr_sp_b: got %h want 40", b_sp); end
    WE = 1'b1; WADDR = 4'd7; WDATA = 8'h10;
    tick;
    WADDR = 4'd2; WDATA = 8'h99; SP_DEC = 1'b1;
    tick;
    WE = 1'b0; SP_DEC = 1'b0; RADDR_A = 4'd2;
    #1;
    total += 4;
    if (a_sp !== 8'h0F) begin bad++; $display("FAIL conf_par_sp_a: got %h want 0f", a_sp); end
    if (b_sp !== 8'h0F) begin bad++; $display("FAIL conf_par_sp_b: got %h want 0f", b_sp); end
    if (a_rd_a !== 8'h99) begin bad++; $display("FAIL conf_par_r2_a: got %h want 99", a_rd_a); end
    if (b_rd_a !== 8'h99) begin bad++; $display("FAIL conf_par_r2_b: got %h want 99", b_rd_a); end
  endtask

  task automatic test_mid_reset;
    RST = 1'b1; WE = 1'b1; WADDR = 4'd1; WDATA = 8'h77; SP_INC = 1'b1;
    tick;
    RST = 1'b0; WE = 1'b0; SP_INC = 1'b0; RADDR_A = 4'd1; RADDR_B = 4'd2;
    #1;
    total += 6;
    if (a_rd_a !== 8'h00) begin bad++; $display("FAIL mrst_r1_a: got %h want 00", a_rd_a); end
    if (b_rd_a !== 8'h00) begin bad++; $display("FAIL mrst_r1_b: got %h want 00", b_rd_a); end
    if (a_rd_b !== 8'h00) begin bad++; $display("FAIL mrst_r2_a: got %h want 00", a_rd_b); end
    if (b_rd_b !== 8'h00) begin bad++; $display("FAIL mrst_r2_b: got %h want 00", b_rd_b); end
    if (a_sp !== 8'hF0) begin bad++; $display("FAIL mrst_sp_a: got %h want f0", a_sp); end
    if (b_sp !== 8'hF0) begin bad++; $display("FAIL mrst_sp_b: got %h want f0", b_sp); end
  endtask

  // Reference read: k=0 is the bypass/normal-R0 config, k=1 no-bypass/zero-R0.
  function automatic logic [7:0] exp_read(input int k, input logic [3:0] ra);
    if (ra >= 4'd8) return 8'h00;
    if ((k == 1) && (ra == 4'd0)) return 8'h00;
    if ((k == 0) && WE && (WADDR < 4'd8) && (ra == WADDR)) return WDATA;
    return mdl[k][ra[2:0]];
  endfunction

  task automatic test_random;
    logic [7:0] ea, eb, es;
    logic       wv;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      RST     = (cyc == 0) || ($urandom_range(0, 63) == 0);
      WE      = 1'($urandom_range(0, 1));
      WADDR   = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
      WDATA   = 8'($urandom);
      RADDR_A = 4'($urandom_range(0, 15));
      RADDR_B = ($urandom_range(0, 2) == 0) ? WADDR : 4'($urandom_range(0, 15));
      SP_INC  = 1'($urandom_range(0, 1));
      SP_DEC  = 1'($urandom_range(0, 1));
      #1;
      if (cyc != 0) begin
        for (int k = 0; k < 2; k++) begin
          ea = exp_read(k, RADDR_A);
          eb = exp_read(k, RADDR_B);
          es = mdl[k][7];
          total += 3;
          if (((k == 0) ? a_rd_a : b_rd_a) !== ea) begin
            bad++; $display("FAIL rnd_rda k=%0d cyc=%0d: got %h want %h", k, cyc, (k == 0) ? a_rd_a : b_rd_a, ea);
          end
          if (((k == 0) ? a_rd_b : b_rd_b) !== eb) begin
            bad++; $display("FAIL rnd_rdb k=%0d cyc=%0d: got %h want %h", k, cyc, (k == 0) ? a_rd_b : b_rd_b, eb);
          end
          if (((k == 0) ? a_sp : b_sp) !== es) begin
            bad++; $display("FAIL rnd_sp k=%0d cyc=%0d: got %h want %h", k, cyc, (k == 0) ? a_sp : b_sp, es);
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (RST) begin
          for (int j = 0; j < 8; j++) mdl[k][j] = 8'h00;
          mdl[k][7] = 8'hF0;
        end else begin
          wv = WE && (WADDR < 4'd8) && !((k == 1) && (WADDR == 4'd0));
          if ((SP_INC ^ SP_DEC) && !(wv && (WADDR == 4'd7))) begin
            mdl[k][7] = SP_INC ? mdl[k][7] + 8'd1 : mdl[k][7] - 8'd1;
          end
          if (wv) mdl[k][WADDR[2:0]] = WDATA;
        end
      end
      tick;
    end
    RST = 1'b0; WE = 1'b0; SP_INC = 1'b0; SP_DEC = 1'b0;
  endtask

  initial begin
    RST = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
    RADDR_A = '0; RADDR_B = '0; SP_INC = 1'b0; SP_DEC = 1'b0;
    #2;
    test_reset;
    test_write_bypass;
    test_invalid_write;
    test_zero_r0;
    test_pointer;
    test_conflict;
    test_mid_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Multi-register storage block for the microprocessor datapath; the parametrised successor to the single enable-gated register. It holds REG_COUNT words of DATA_WIDTH bits with two combinational read ports and one clocked write port. It adds an optional hardwired-zero R0, optional write-to-read bypass, and a dedicated pointer register (stack pointer) with increment/decrement, wrap-around and a configurable reset value.

## Interface
- DATA_WIDTH, 8, width of every register and data port
- REG_COUNT, 8, number of registers; must be >= 2
- ADDR_WIDTH, 3, address width; must satisfy 2**ADDR_WIDTH >= REG_COUNT
- ZERO_R0, 0, when 1, register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1, a read of the register being written in the same cycle returns WDATA
- SP_ADDR, REG_COUNT-1, index of the pointer register; must be < REG_COUNT and, with ZERO_R0=1, != 0
- SP_RESET, 0, reset value of the pointer register (DATA_WIDTH bits)

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset; one clock, synchronous, active-high
- WE  input  1  write enable
- WADDR  input  ADDR_WIDTH  write address
- WDATA  input  DATA_WIDTH  write data
- RADDR_A  input  ADDR_WIDTH  read address, port A
- RADDR_B  input  ADDR_WIDTH  read address, port B
- RDATA_A  output  DATA_WIDTH  read data, port A (combinational)
- RDATA_B  output  DATA_WIDTH  read data, port B (combinational)
- SP_INC  input  1  increment pointer register by 1
- SP_DEC  input  1  decrement pointer register by 1
- SP_OUT  output  DATA_WIDTH  current pointer register value (direct from flop)

## Operation
- Reset (RST=1 at a rising edge): every register is cleared to 0, except SP_ADDR, which loads SP_RESET. RST overrides WE, SP_INC and SP_DEC in the same cycle. Reset mid-operation discards any pending write or pointer step.
- Write: WE=1 and WADDR < REG_COUNT stores WDATA into register WADDR at the edge. WADDR >= REG_COUNT is ignored (no register changes). With ZERO_R0=1, a write to address 0 is ignored.
- Read: RDATA_x = register[RADDR_x]. RADDR_x >= REG_COUNT returns 0. With ZERO_R0=1, address 0 returns 0.
- Bypass (BYPASS=1): if WE=1, WADDR is valid and writable, and RADDR_x == WADDR, then RDATA_x = WDATA in that cycle. Both ports bypass independently.
- Pointer step, applied to register SP_ADDR:
  - SP_INC=1, SP_DEC=0: +1 modulo 2**DATA_WIDTH, so all-ones wraps to 0.
  - SP_DEC=1, SP_INC=0: -1 modulo, so 0 wraps to all-ones.
  - SP_INC=SP_DEC=1: no change.
- Priority on the pointer register: RST > WE write to SP_ADDR > pointer step. A write to SP_ADDR in the same cycle as a step stores WDATA unmodified and discards the step. A write to any other register proceeds in parallel with a step.
- Bypass covers WE writes only. Pointer steps are never bypassed; RDATA at SP_ADDR shows the pre-step value until the edge.
- SP_OUT always equals stored register[SP_ADDR], with no bypass.

## Timing
- Write and pointer-step latency: 1 cycle. The new value is visible on RDATA/SP_OUT after the rising edge.
- Read latency: 0 cycles (combinational from address). With BYPASS=1 there is also a combinational path from WDATA/WE/WADDR to RDATA.
- Output values after reset:
  - RDATA_A/B = 0 for all addresses except SP_ADDR, which reads SP_RESET.
  - SP_OUT = SP_RESET.
- No handshake; all inputs are sampled every cycle and there are no stall or ready signals.
- A back-to-back write then read of the same address returns the new data in the following cycle; it returns it in the same cycle if BYPASS=1.

## Test plan
- Reset with defaults and SP_RESET=8'hF0, then sweep RADDR_A over 0..7: all read 0 except addr 7 = 8'hF0; SP_OUT = 8'hF0.
- Write 8'hA5 to addr 3 while RADDR_A=3 and RADDR_B=3: BYPASS=1 gives 8'hA5 on both in the same cycle; BYPASS=0 gives the old value 0, then 8'hA5 next cycle. Write to addr 9 with REG_COUNT=8: no register changes.
- ZERO_R0=1: write 8'h55 to addr 0, read addr 0 -> 0, including during the write cycle with BYPASS=1.
- Pointer: SP=8'hFF, pulse SP_INC -> 8'h00; SP=8'h00, pulse SP_DEC -> 8'hFF; SP_INC=SP_DEC=1 -> unchanged.
- Conflict: SP=8'h10, WE to SP_ADDR with 8'h40 plus SP_INC -> 8'h40. WE to addr 2 plus SP_DEC -> addr 2 written and SP = 8'h0F.
- Mid-operation reset: RST=1 with WE=1 (addr 1, 8'h77) and SP_INC=1 -> addr 1 = 0, SP = SP_RESET; a randomized 1000-cycle run against a reference model reports no mismatches.
